// File: rtl/link_tx_credit.sv
// link_tx_credit: credit-based writer into a neighbour router's input FIFO, with packet framing
// Optional feature macro: LINK_TX_STATS_EN adds flit_cnt and stall_cnt counters.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   src_valid  flit offered by switch/crossbar
//   src_data   offered flit (head flit: bits[2:0] = number of body flits)
//   src_ready  flit accepted this cycle (comb, credits != 0)
//   credit_in  one-cycle pulse, downstream FIFO popped one flit
//   write      downstream FIFO write strobe (registered)
//   data_out   downstream FIFO data_in (registered, holds when idle)
//   pkt_active packet in flight, allocator keeps this port granted
//   credits    free downstream slots
//   credit_err sticky, credit returned while already at DEPTH
//   flit_cnt   (LINK_TX_STATS_EN) accepted flits, wrapping
//   stall_cnt  (LINK_TX_STATS_EN) cycles with src_valid && !src_ready, saturating
module link_tx_credit #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          src_valid,
    input  logic [7:0]    src_data,
    output logic          src_ready,
    input  logic          credit_in,
    output logic          write,
    output logic [7:0]    data_out,
    output logic          pkt_active,
    output logic [CW-1:0] credits,
    output logic          credit_err
`ifdef LINK_TX_STATS_EN
    ,
    output logic [15:0]   flit_cnt,
    output logic [15:0]   stall_cnt
`endif
);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic {IDLE, BODY} state_t;
    state_t state, state_d;
    logic [2:0] remaining, remaining_d;
    logic accept;
    assign src_ready  = credits != '0;
    assign accept     = src_valid && src_ready;
    assign pkt_active = (state == BODY) || (src_valid && state == IDLE);
    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        if (accept) begin
            if (state == IDLE) begin
                state_d     = src_data[2:0] != 3'd0 ? BODY : IDLE;
                remaining_d = src_data[2:0];
            end else begin
                state_d     = remaining == 3'd1 ? IDLE : BODY;
                remaining_d = remaining - 3'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= 3'd0;
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write    <= 1'b0;
            data_out <= 8'd0;
        end else begin
            write <= accept;
            if (accept)
                data_out <= src_data;
        end
    end
    // A return with a simultaneous accept cancels out; a return at FULL
    // without an accept means the neighbour sent a credit it never owed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits    <= FULL;
            credit_err <= 1'b0;
        end else if (accept && !credit_in) begin
            credits <= credits - 1'b1;
        end else if (credit_in && !accept) begin
            if (credits == FULL)
                credit_err <= 1'b1;
            else
                credits <= credits + 1'b1;
        end
    end
`ifdef LINK_TX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_cnt  <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (accept)
                flit_cnt <= flit_cnt + 16'd1;
            if (src_valid && !src_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_link_tx_credit.sv
// tb_link_tx_credit: directed and random checks of link_tx_credit against a flit/credit reference model
module tb_link_tx_credit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'd0;
    logic       credit_in = 1'b0;
    logic       src_ready, write, pkt_active, credit_err;
    logic [7:0] data_out;
    logic [3:0] credits;
`ifdef LINK_TX_STATS_EN
    logic [15:0] flit_cnt, stall_cnt;
`endif
    int passed = 0;
    int total = 0;
    int m_cred, m_rem, m_err, m_wr, m_data, m_flits, m_stall, writes_seen;

    always #5 clk = ~clk;

    link_tx_credit #(.DEPTH(8), .CW(4)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .credit_in(credit_in), .write(write),
        .data_out(data_out), .pkt_active(pkt_active), .credits(credits),
        .credit_err(credit_err)
`ifdef LINK_TX_STATS_EN
        , .flit_cnt(flit_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cred = 8; m_rem = 0; m_err = 0; m_wr = 0; m_data = 0; m_flits = 0; m_stall = 0;
    endtask

    task automatic check_regs();
        chk("write", write, m_wr);
        chk("data_out", data_out, m_data);
        chk("credits", credits, m_cred);
        chk("credit_err", credit_err, m_err);
`ifdef LINK_TX_STATS_EN
        chk("flit_cnt", flit_cnt, m_flits);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    // One clock: drive at negedge, check comb outputs, then registered outputs after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic c);
        bit acc;
        @(negedge clk);
        src_valid = v; src_data = d; credit_in = c;
        #1;
        chk("src_ready", src_ready, m_cred != 0);
        chk("pkt_active", pkt_active, (m_rem > 0) || v);
        acc = v && (m_cred != 0);
        @(posedge clk);
        m_wr = acc;
        if (acc) begin
            m_data = d;
            m_rem = (m_rem == 0) ? int'(d[2:0]) : m_rem - 1;
            m_flits = (m_flits + 1) & 32'hFFFF;
        end
        if (v && !acc && m_stall < 32'hFFFF) m_stall++;
        if (acc && !c) m_cred--;
        else if (c && !acc) begin
            if (m_cred == 8) m_err = 1;
            else m_cred++;
        end
        #1;
        if (write) writes_seen++;
        check_regs();
    endtask

    task automatic mid_reset();
        @(negedge clk);
        src_valid = 1'b0; credit_in = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_write", write, 0);
        chk("rst_credits", credits, 8);
        chk("rst_pkt_active", pkt_active, 0);
        chk("rst_credit_err", credit_err, 0);
        check_regs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_write", write, 0);
        chk("por_credits", credits, 8);
        chk("por_pkt_active", pkt_active, 0);
        chk("por_credit_err", credit_err, 0);
        @(negedge clk);
        rst = 1'b1;
        // single flit
        step(1, 8'hA0, 0);
        chk("t2_write", write, 1);
        chk("t2_data", data_out, 8'hA0);
        chk("t2_credits", credits, 7);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        // exhaustion
        writes_seen = 0;
        for (int i = 0; i < 10; i++) step(1, 8'h08, 0);
        chk("t3_writes", writes_seen, 8);
        chk("t3_ready", src_ready, 0);
        writes_seen = 0;
        step(1, 8'h20, 1);
        step(1, 8'h20, 0);
        step(1, 8'h20, 0);
        chk("t3_one_more", writes_seen, 1);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1);
        // packet + back-to-back head
        step(1, 8'h13, 1);
        for (int i = 0; i < 3; i++) step(1, 8'h55 + 8'(i), 0);
        chk("t4_last_body", data_out, 8'h57);
        step(1, 8'h40, 0);
        chk("t4_next_head", data_out, 8'h40);
        step(0, 8'h00, 0);
        chk("t4_idle_pkt", pkt_active, 0);
        while (m_cred < 8) step(0, 8'h00, 1);
        // simultaneous accept and return
        for (int i = 0; i < 3; i++) step(1, 8'h00, 0);
        step(1, 8'hA0, 1);
        chk("t5_credits", credits, 5);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        // overflow
        step(0, 8'h00, 1);
        chk("t6_credits", credits, 8);
        chk("t6_err", credit_err, 1);
        step(1, 8'h00, 0);
        step(0, 8'h00, 1);
        chk("t6_err_sticky", credit_err, 1);
        mid_reset();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic v, c;
            v = ($urandom_range(3) != 0);
            c = (m_cred < 8) ? ($urandom_range(1) == 1) : ($urandom_range(40) == 0);
            step(v, 8'($urandom), c);
            if (i == 300) mid_reset();
        end
        // reset with a packet in flight
        step(1, 8'h07, 0);
        step(1, 8'h11, 0);
        mid_reset();
        step(1, 8'h00, 0);
        chk("post_rst_single", write, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
